// File: rtl/temp_ctrl_axil_slave.sv
// AXI4-Lite register file for the temperature controller: control/setpoint/hysteresis
// registers, sampled sensor temperature, and a hysteresis-driven heater output.
module temp_ctrl_axil_slave #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 5,
    parameter int TEMP_WIDTH         = 12
) (
    input  logic                            ACLK,
    input  logic                            ARESET,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic                            S_AXI_AWVALID,
    output logic                            S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                            S_AXI_WVALID,
    output logic                            S_AXI_WREADY,
    output logic [1:0]                      S_AXI_BRESP,
    output logic                            S_AXI_BVALID,
    input  logic                            S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic                            S_AXI_ARVALID,
    output logic                            S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                      S_AXI_RRESP,
    output logic                            S_AXI_RVALID,
    input  logic                            S_AXI_RREADY,
    input  logic [TEMP_WIDTH-1:0]           temp_in,
    output logic                            heater_on
);
    localparam int DW = C_S_AXI_DATA_WIDTH;
    localparam int SW = C_S_AXI_DATA_WIDTH / 8;

    typedef enum logic {W_IDLE, W_RESP} wstate_t;
    typedef enum logic {R_IDLE, R_DATA} rstate_t;

    wstate_t          wstate_q;
    rstate_t          rstate_q;
    logic             rst_done_q;
    logic             aw_lat_q, w_lat_q;
    logic [2:0]       awidx_q;
    logic [DW-1:0]    wdata_q;
    logic [SW-1:0]    wstrb_q;
    logic             bvalid_q, rvalid_q;
    logic [1:0]       bresp_q, rresp_q;
    logic [DW-1:0]    rdata_q;
    logic [DW-1:0]    ctrl_q, setpoint_q, hyst_q, scratch_q;
    logic [TEMP_WIDTH-1:0] temp_q;
    logic             heater_q;

    logic             aw_fire, w_fire, wr_commit, rd_err;
    logic [2:0]       wr_idx, rd_idx;
    logic [DW-1:0]    wr_data, rd_word;
    logic [SW-1:0]    wr_strb;
    logic [TEMP_WIDTH-1:0] sp, hy, lo, hi;
    logic [TEMP_WIDTH:0]   sum;
    logic             unused_addr_lsbs;

    assign unused_addr_lsbs = ^{S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

    assign S_AXI_AWREADY = rst_done_q && (wstate_q == W_IDLE) && !aw_lat_q;
    assign S_AXI_WREADY  = rst_done_q && (wstate_q == W_IDLE) && !w_lat_q;
    assign S_AXI_ARREADY = rst_done_q && (rstate_q == R_IDLE);
    assign S_AXI_BVALID  = bvalid_q;
    assign S_AXI_BRESP   = bresp_q;
    assign S_AXI_RVALID  = rvalid_q;
    assign S_AXI_RRESP   = rresp_q;
    assign S_AXI_RDATA   = rdata_q;
    assign heater_on     = heater_q;

    assign aw_fire   = S_AXI_AWVALID && S_AXI_AWREADY;
    assign w_fire    = S_AXI_WVALID && S_AXI_WREADY;
    // A channel counts as present if latched earlier or handshaking this cycle.
    assign wr_commit = (wstate_q == W_IDLE) && (aw_lat_q || aw_fire) && (w_lat_q || w_fire);
    assign wr_idx    = aw_lat_q ? awidx_q : S_AXI_AWADDR[4:2];
    assign wr_data   = w_lat_q ? wdata_q : S_AXI_WDATA;
    assign wr_strb   = w_lat_q ? wstrb_q : S_AXI_WSTRB;
    assign rd_idx    = S_AXI_ARADDR[4:2];

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] old_v,
                                            input logic [DW-1:0] new_v,
                                            input logic [SW-1:0] strb);
        logic [DW-1:0] r;
        r = old_v;
        for (int unsigned k = 0; k < SW; k++)
            if (strb[k]) r[8*k +: 8] = new_v[8*k +: 8];
        return r;
    endfunction

    always_comb begin
        rd_word = '0;
        rd_err  = 1'b0;
        case (rd_idx)
            3'd0: rd_word = ctrl_q;
            3'd1: rd_word = setpoint_q;
            3'd2: rd_word = hyst_q;
            3'd3: rd_word = scratch_q;
            3'd4: rd_word = {{(DW-TEMP_WIDTH){1'b0}}, temp_q};
            3'd5: rd_word = {{(DW-2){1'b0}}, ctrl_q[0], heater_q};
            default: rd_err = 1'b1;
        endcase
    end

    always_comb begin
        sp  = setpoint_q[TEMP_WIDTH-1:0];
        hy  = hyst_q[TEMP_WIDTH-1:0];
        sum = {1'b0, sp} + {1'b0, hy};
        hi  = sum[TEMP_WIDTH] ? '1 : sum[TEMP_WIDTH-1:0];
        lo  = (sp > hy) ? sp - hy : '0;
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            rst_done_q <= 1'b0;
            temp_q     <= '0;
            heater_q   <= 1'b0;
        end else begin
            rst_done_q <= 1'b1;
            temp_q     <= temp_in;
            if (!ctrl_q[0])        heater_q <= 1'b0;
            else if (temp_in < lo) heater_q <= 1'b1;
            else if (temp_in > hi) heater_q <= 1'b0;
        end
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            wstate_q   <= W_IDLE;
            aw_lat_q   <= 1'b0;
            w_lat_q    <= 1'b0;
            awidx_q    <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            bvalid_q   <= 1'b0;
            bresp_q    <= 2'b00;
            ctrl_q     <= '0;
            setpoint_q <= '0;
            hyst_q     <= '0;
            scratch_q  <= '0;
        end else begin
            case (wstate_q)
                W_IDLE: begin
                    if (wr_commit) begin
                        aw_lat_q <= 1'b0;
                        w_lat_q  <= 1'b0;
                        bvalid_q <= 1'b1;
                        bresp_q  <= (wr_idx < 3'd4) ? 2'b00 : 2'b10;
                        wstate_q <= W_RESP;
                        case (wr_idx)
                            3'd0: ctrl_q     <= merge(ctrl_q, wr_data, wr_strb);
                            3'd1: setpoint_q <= merge(setpoint_q, wr_data, wr_strb);
                            3'd2: hyst_q     <= merge(hyst_q, wr_data, wr_strb);
                            3'd3: scratch_q  <= merge(scratch_q, wr_data, wr_strb);
                            default: ;
                        endcase
                    end else begin
                        if (aw_fire) begin
                            aw_lat_q <= 1'b1;
                            awidx_q  <= S_AXI_AWADDR[4:2];
                        end
                        if (w_fire) begin
                            w_lat_q <= 1'b1;
                            wdata_q <= S_AXI_WDATA;
                            wstrb_q <= S_AXI_WSTRB;
                        end
                    end
                end
                W_RESP: begin
                    if (S_AXI_BREADY) begin
                        bvalid_q <= 1'b0;
                        wstate_q <= W_IDLE;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            rstate_q <= R_IDLE;
            rvalid_q <= 1'b0;
            rresp_q  <= 2'b00;
            rdata_q  <= '0;
        end else begin
            case (rstate_q)
                R_IDLE: begin
                    if (S_AXI_ARVALID && S_AXI_ARREADY) begin
                        rdata_q  <= rd_word;
                        rresp_q  <= rd_err ? 2'b10 : 2'b00;
                        rvalid_q <= 1'b1;
                        rstate_q <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (S_AXI_RREADY) begin
                        rvalid_q <= 1'b0;
                        rstate_q <= R_IDLE;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_temp_ctrl_axil_slave.sv
// Directed self-checking bench for temp_ctrl_axil_slave.
module tb_temp_ctrl_axil_slave;
    logic        ACLK = 1'b0;
    logic        ARESET = 1'b1;
    logic [4:0]  S_AXI_AWADDR = '0;
    logic        S_AXI_AWVALID = 1'b0;
    logic        S_AXI_AWREADY;
    logic [31:0] S_AXI_WDATA = '0;
    logic [3:0]  S_AXI_WSTRB = '0;
    logic        S_AXI_WVALID = 1'b0;
    logic        S_AXI_WREADY;
    logic [1:0]  S_AXI_BRESP;
    logic        S_AXI_BVALID;
    logic        S_AXI_BREADY = 1'b0;
    logic [4:0]  S_AXI_ARADDR = '0;
    logic        S_AXI_ARVALID = 1'b0;
    logic        S_AXI_ARREADY;
    logic [31:0] S_AXI_RDATA;
    logic [1:0]  S_AXI_RRESP;
    logic        S_AXI_RVALID;
    logic        S_AXI_RREADY = 1'b0;
    logic [11:0] temp_in = '0;
    logic        heater_on;

    int n_checks = 0;
    int n_fail = 0;

    temp_ctrl_axil_slave #(
        .C_S_AXI_DATA_WIDTH(32),
        .C_S_AXI_ADDR_WIDTH(5),
        .TEMP_WIDTH(12)
    ) dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
        .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB),
        .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY),
        .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID), .S_AXI_BREADY(S_AXI_BREADY),
        .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
        .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
        .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY),
        .temp_in(temp_in), .heater_on(heater_on)
    );

    always #5 ACLK = ~ACLK;

    // Bus driver: inputs change on falling edges; a valid&ready seen there fires on the next rising edge.
    task automatic axi_write(input logic [4:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             input int unsigned aw_dly, input int unsigned w_dly, input int unsigned b_dly,
                             output logic [1:0] resp, output logic ok, output logic lat_ok,
                             output logic hold_ok, output logic single_ok);
        int unsigned cyc;
        logic aw_done, w_done;
        aw_done = 1'b0; w_done = 1'b0; resp = 2'b11;
        ok = 1'b1; lat_ok = 1'b0; hold_ok = 1'b1; single_ok = 1'b1;
        @(negedge ACLK);
        S_AXI_AWADDR = addr; S_AXI_WDATA = data; S_AXI_WSTRB = strb; S_AXI_BREADY = 1'b0;
        cyc = 0;
        while (!(aw_done && w_done) && cyc < 40) begin
            S_AXI_AWVALID = !aw_done && (cyc >= aw_dly);
            S_AXI_WVALID  = !w_done && (cyc >= w_dly);
            if (S_AXI_AWVALID && S_AXI_AWREADY) aw_done = 1'b1;
            if (S_AXI_WVALID && S_AXI_WREADY) w_done = 1'b1;
            @(negedge ACLK);
            cyc++;
        end
        S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
        if (!(aw_done && w_done)) begin
            ok = 1'b0;
            return;
        end
        lat_ok = S_AXI_BVALID;
        cyc = 0;
        while (!S_AXI_BVALID && cyc < 20) begin
            @(negedge ACLK);
            cyc++;
        end
        if (!S_AXI_BVALID) begin
            ok = 1'b0;
            return;
        end
        for (int unsigned i = 0; i < b_dly; i++) begin
            @(negedge ACLK);
            if (!S_AXI_BVALID) hold_ok = 1'b0;
        end
        S_AXI_BREADY = 1'b1;
        resp = S_AXI_BRESP;
        @(negedge ACLK);
        S_AXI_BREADY = 1'b0;
        if (S_AXI_BVALID) single_ok = 1'b0;
        @(negedge ACLK);
        if (S_AXI_BVALID) single_ok = 1'b0;
    endtask

    task automatic axi_read(input logic [4:0] addr, output logic [31:0] data,
                            output logic [1:0] resp, output logic ok);
        int unsigned cyc;
        ok = 1'b1; data = 32'hDEAD_BEEF; resp = 2'b11;
        @(negedge ACLK);
        S_AXI_ARADDR = addr; S_AXI_ARVALID = 1'b1; S_AXI_RREADY = 1'b0;
        cyc = 0;
        while (!S_AXI_ARREADY && cyc < 20) begin
            @(negedge ACLK);
            cyc++;
        end
        @(negedge ACLK);
        S_AXI_ARVALID = 1'b0;
        cyc = 0;
        while (!S_AXI_RVALID && cyc < 20) begin
            @(negedge ACLK);
            cyc++;
        end
        if (!S_AXI_RVALID) begin
            ok = 1'b0;
            return;
        end
        data = S_AXI_RDATA; resp = S_AXI_RRESP;
        S_AXI_RREADY = 1'b1;
        @(negedge ACLK);
        S_AXI_RREADY = 1'b0;
    endtask

    task automatic test_reset();
        ARESET = 1'b1;
        repeat (3) @(negedge ACLK);
        n_checks++;
        if ({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY, S_AXI_BVALID, S_AXI_RVALID} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_handshakes: got %b want 00000",
                     {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY, S_AXI_BVALID, S_AXI_RVALID});
        end
        n_checks++;
        if ({S_AXI_BRESP, S_AXI_RRESP, S_AXI_RDATA, heater_on} !== 37'b0) begin
            n_fail++;
            $display("FAIL reset_data: bresp=%b rresp=%b rdata=%h heater=%b want all zero",
                     S_AXI_BRESP, S_AXI_RRESP, S_AXI_RDATA, heater_on);
        end
        ARESET = 1'b0;
        repeat (2) @(negedge ACLK);
        n_checks++;
        if ({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY} !== 3'b111) begin
            n_fail++;
            $display("FAIL idle_ready: got %b want 111", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY});
        end
    endtask

    task automatic test_basic_rw();
        logic [1:0] resp; logic ok, lat, hold, single;
        logic [31:0] d;
        for (int unsigned i = 0; i < 4; i++) begin
            axi_write(5'(4*i), 32'(i + 1), 4'hF, 0, 0, 0, resp, ok, lat, hold, single);
            n_checks++;
            if (!ok || !lat || resp !== 2'b00) begin
                n_fail++;
                $display("FAIL basic_write[%0d]: ok=%b lat=%b bresp=%b want ok=1 lat=1 bresp=00", i, ok, lat, resp);
            end
        end
        for (int unsigned i = 0; i < 4; i++) begin
            axi_read(5'(4*i), d, resp, ok);
            n_checks++;
            if (!ok || d !== 32'(i + 1) || resp !== 2'b00) begin
                n_fail++;
                $display("FAIL basic_read[%0d]: ok=%b data=%h rresp=%b want data=%h rresp=00", i, ok, d, resp, 32'(i + 1));
            end
        end
    endtask

    task automatic test_channel_order();
        logic [1:0] resp; logic ok, lat, hold, single;
        logic [31:0] d;
        int unsigned awd [3];
        int unsigned wd [3];
        logic [31:0] val [3];
        awd[0] = 0; wd[0] = 3; val[0] = 32'h0000_A001;
        awd[1] = 3; wd[1] = 0; val[1] = 32'h0000_B002;
        awd[2] = 0; wd[2] = 0; val[2] = 32'h0000_C003;
        for (int unsigned i = 0; i < 3; i++) begin
            axi_write(5'h0C, val[i], 4'hF, awd[i], wd[i], 5, resp, ok, lat, hold, single);
            n_checks++;
            if (!ok || !lat || !hold || !single || resp !== 2'b00) begin
                n_fail++;
                $display("FAIL order_bresp[%0d]: ok=%b lat=%b hold=%b single=%b bresp=%b want all 1, 00",
                         i, ok, lat, hold, single, resp);
            end
            axi_read(5'h0C, d, resp, ok);
            n_checks++;
            if (!ok || d !== val[i]) begin
                n_fail++;
                $display("FAIL order_data[%0d]: got %h want %h", i, d, val[i]);
            end
        end
    endtask

    task automatic test_wstrb();
        logic [1:0] resp; logic ok, lat, hold, single;
        logic [31:0] d;
        axi_write(5'h0C, 32'h1122_3344, 4'hF, 0, 0, 0, resp, ok, lat, hold, single);
        axi_write(5'h0C, 32'hAABB_CCDD, 4'b0010, 0, 0, 0, resp, ok, lat, hold, single);
        axi_read(5'h0C, d, resp, ok);
        n_checks++;
        if (!ok || d !== 32'h1122_CC44) begin
            n_fail++;
            $display("FAIL wstrb_merge: got %h want 1122cc44", d);
        end
    endtask

    task automatic test_ro_unmapped();
        logic [1:0] resp; logic ok, lat, hold, single;
        logic [31:0] d;
        temp_in = 12'hABC;
        repeat (2) @(negedge ACLK);
        axi_write(5'h10, 32'hFFFF_FFFF, 4'hF, 0, 0, 0, resp, ok, lat, hold, single);
        n_checks++;
        if (!ok || resp !== 2'b10) begin
            n_fail++;
            $display("FAIL ro_write_bresp: got %b want 10", resp);
        end
        axi_read(5'h10, d, resp, ok);
        n_checks++;
        if (!ok || d !== 32'h0000_0ABC || resp !== 2'b00) begin
            n_fail++;
            $display("FAIL temp_read: data=%h rresp=%b want 00000abc/00", d, resp);
        end
        axi_write(5'h18, 32'h1234_5678, 4'hF, 0, 0, 0, resp, ok, lat, hold, single);
        n_checks++;
        if (!ok || resp !== 2'b10) begin
            n_fail++;
            $display("FAIL unmapped_write_bresp: got %b want 10", resp);
        end
        axi_read(5'h1C, d, resp, ok);
        n_checks++;
        if (!ok || d !== 32'h0 || resp !== 2'b10) begin
            n_fail++;
            $display("FAIL unmapped_read: data=%h rresp=%b want 00000000/10", d, resp);
        end
        // enable=1 from CTRL=1; SP=2,H=3 gives hi=5 so temp 0xABC keeps heater off.
        axi_read(5'h14, d, resp, ok);
        n_checks++;
        if (!ok || d !== 32'h2 || resp !== 2'b00) begin
            n_fail++;
            $display("FAIL status_read: data=%h rresp=%b want 00000002/00", d, resp);
        end
    endtask

    task automatic test_heater();
        logic [1:0] resp; logic ok, lat, hold, single;
        logic [11:0] tv [5];
        logic        ev [5];
        tv[0] = 12'd94;  ev[0] = 1'b1;
        tv[1] = 12'd97;  ev[1] = 1'b1;
        tv[2] = 12'd106; ev[2] = 1'b0;
        tv[3] = 12'd103; ev[3] = 1'b0;
        tv[4] = 12'd94;  ev[4] = 1'b1;
        axi_write(5'h04, 32'd100, 4'hF, 0, 0, 0, resp, ok, lat, hold, single);
        axi_write(5'h08, 32'd5, 4'hF, 0, 0, 0, resp, ok, lat, hold, single);
        axi_write(5'h00, 32'd1, 4'hF, 0, 0, 0, resp, ok, lat, hold, single);
        for (int unsigned i = 0; i < 5; i++) begin
            temp_in = tv[i];
            @(negedge ACLK);
            n_checks++;
            if (heater_on !== ev[i]) begin
                n_fail++;
                $display("FAIL heater_seq[%0d] temp=%0d: got %b want %b", i, tv[i], heater_on, ev[i]);
            end
        end
        axi_write(5'h00, 32'd0, 4'hF, 0, 0, 0, resp, ok, lat, hold, single);
        n_checks++;
        if (heater_on !== 1'b0) begin
            n_fail++;
            $display("FAIL heater_disable: got %b want 0", heater_on);
        end
        axi_write(5'h04, 32'd4095, 4'hF, 0, 0, 0, resp, ok, lat, hold, single);
        axi_write(5'h08, 32'd10, 4'hF, 0, 0, 0, resp, ok, lat, hold, single);
        axi_write(5'h00, 32'd1, 4'hF, 0, 0, 0, resp, ok, lat, hold, single);
        n_checks++;
        if (heater_on !== 1'b1) begin
            n_fail++;
            $display("FAIL heater_sat_on: got %b want 1", heater_on);
        end
        temp_in = 12'd4095;
        @(negedge ACLK);
        n_checks++;
        if (heater_on !== 1'b1) begin
            n_fail++;
            $display("FAIL heater_hi_saturated: got %b want 1", heater_on);
        end
        // SP=3,H=10: lo clamps to 0, hi=13.
        axi_write(5'h04, 32'd3, 4'hF, 0, 0, 0, resp, ok, lat, hold, single);
        n_checks++;
        if (heater_on !== 1'b0) begin
            n_fail++;
            $display("FAIL heater_above_hi: got %b want 0", heater_on);
        end
        temp_in = 12'd0;
        repeat (2) @(negedge ACLK);
        n_checks++;
        if (heater_on !== 1'b0) begin
            n_fail++;
            $display("FAIL heater_lo_clamped: got %b want 0", heater_on);
        end
    endtask

    task automatic test_reset_mid_read();
        logic [1:0] resp; logic ok;
        logic [31:0] d;
        int unsigned cyc;
        @(negedge ACLK);
        S_AXI_ARADDR = 5'h0C; S_AXI_ARVALID = 1'b1; S_AXI_RREADY = 1'b0;
        cyc = 0;
        while (!S_AXI_RVALID && cyc < 20) begin
            @(negedge ACLK);
            S_AXI_ARVALID = 1'b0;
            cyc++;
        end
        S_AXI_ARVALID = 1'b0;
        n_checks++;
        if (S_AXI_RVALID !== 1'b1) begin
            n_fail++;
            $display("FAIL rvalid_before_reset: got %b want 1", S_AXI_RVALID);
        end
        #2 ARESET = 1'b1;
        #1;
        n_checks++;
        if (S_AXI_RVALID !== 1'b0) begin
            n_fail++;
            $display("FAIL rvalid_async_drop: got %b want 0", S_AXI_RVALID);
        end
        repeat (2) @(negedge ACLK);
        ARESET = 1'b0;
        repeat (2) @(negedge ACLK);
        for (int unsigned i = 0; i < 4; i++) begin
            axi_read(5'(4*i), d, resp, ok);
            n_checks++;
            if (!ok || d !== 32'h0 || resp !== 2'b00) begin
                n_fail++;
                $display("FAIL post_reset_reg[%0d]: data=%h rresp=%b want 0/00", i, d, resp);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic_rw();
        test_channel_order();
        test_wstrb();
        test_ro_unmapped();
        test_heater();
        test_reset_mid_read();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/temp_ctrl_axil_slave.md
Name: temp_ctrl_axil_slave

Overview:
AXI4-Lite slave register file for the Temperature_Control IP, acting as the responder to the master VIP/PS initiator. It holds control, setpoint and hysteresis registers, and samples the sensor temperature. It drives a hysteresis-based heater output.

Parameters:
C_S_AXI_DATA_WIDTH, 32, AXI data width (fixed 32).
C_S_AXI_ADDR_WIDTH, 5, byte address width (8 word slots).
TEMP_WIDTH, 12, unsigned temperature/setpoint/hysteresis width.

Ports:
ACLK  in  1  clock, rising edge.
ARESET  in  1  asynchronous active-high reset.
S_AXI_AWADDR  in  5  write address.
S_AXI_AWVALID / S_AXI_AWREADY  in/out  1  write address handshake.
S_AXI_WDATA  in  32  write data.
S_AXI_WSTRB  in  4  byte enables.
S_AXI_WVALID / S_AXI_WREADY  in/out  1  write data handshake.
S_AXI_BRESP  out  2  write response.
S_AXI_BVALID / S_AXI_BREADY  out/in  1  write response handshake.
S_AXI_ARADDR  in  5  read address.
S_AXI_ARVALID / S_AXI_ARREADY  in/out  1  read address handshake.
S_AXI_RDATA  out  32  read data.
S_AXI_RRESP  out  2  read response.
S_AXI_RVALID / S_AXI_RREADY  out/in  1  read data handshake.
temp_in  in  TEMP_WIDTH  sensor temperature, synchronous to ACLK.
heater_on  out  1  heater drive.

Behaviour:
- Register map (word index = addr[4:2]; addr[1:0] ignored):
  - 0x00 CTRL RW: bit0 enable. Bits 31:1 are storage-only scratch and read back as written.
  - 0x04 SETPOINT RW, 32-bit storage; logic uses [TEMP_WIDTH-1:0].
  - 0x08 HYST RW, 32-bit storage; logic uses [TEMP_WIDTH-1:0].
  - 0x0C SCRATCH RW.
  - 0x10 TEMP RO: zero-extended temp_in, sampled every cycle.
  - 0x14 STATUS RO: bit0 heater_on, bit1 enable.
  - 0x18–0x1C unmapped.
- Reset (async assert, sync release to ACLK): all ready/valid outputs 0, BRESP/RRESP 0, RDATA 0, all registers 0, heater_on 0.
- Write FSM states W_IDLE, W_RESP:
  - AWREADY is high in W_IDLE while no address is latched. WREADY is high in W_IDLE while no data is latched.
  - AW and W are accepted independently, in either order or in the same cycle. Each is latched once accepted.
  - Once both are latched: the register update happens on that edge, BVALID=1, and the FSM enters W_RESP. Minimum latency is AW+W accepted on cycle N, BVALID on N+1.
  - In W_RESP, AWREADY=WREADY=0. BVALID holds until BREADY, then returns to W_IDLE.
  - WSTRB[k] enables byte k. Strobe 0 leaves the byte unchanged.
  - Writes to RO or unmapped addresses do not change state.
  - BRESP: OKAY (00) for 0x00–0x0C; SLVERR (10) for RO or unmapped addresses.
- Read FSM states R_IDLE, R_DATA:
  - ARREADY=1 in R_IDLE. On acceptance, RDATA/RRESP are registered and RVALID=1 on the next cycle.
  - RDATA is held stable until RREADY, then the FSM returns to R_IDLE.
  - RRESP: OKAY for 0x00–0x14. SLVERR with RDATA=0 for unmapped addresses.
  - Only one read is outstanding; ARREADY=0 in R_DATA.
- Simultaneous read and write to the same register: the read returns the pre-write value when its AR is accepted on or before the write-commit edge.
- Heater logic, registered, 1-cycle latency from temp_in:
  - lo = (SP > H) ? SP-H : 0. hi = min(SP+H, 2^TEMP_WIDTH-1), computed in TEMP_WIDTH+1 bits and saturated.
  - When enable=0: heater_on <= 0.
  - Otherwise: temp_in < lo → 1; temp_in > hi → 0; else hold.
  - A CTRL write clearing enable forces heater_on to 0 on the following edge.
- Reset mid-transaction aborts the transaction: BVALID/RVALID drop immediately and the master must reissue.

Test Plan:
- After reset, write 0x1, 0x2, 0x3, 0x4 to 0x00–0x0C, then read them back → data equal, all BRESP/RRESP=OKAY.
- AW issued 3 cycles before W, then W before AW, then both in the same cycle → each commits once, exactly one BVALID per write, with BVALID held under BREADY=0 for 5 cycles.
- WSTRB=0b0010 with data 0xAABBCCDD to SCRATCH=0x11223344 → readback 0x1122CC44.
- Write to 0x10, then read 0x1C → BRESP=SLVERR with TEMP unchanged; RRESP=SLVERR with RDATA=0.
- SETPOINT=100, HYST=5, enable=1; temp_in sequence 94, 97, 106, 103, 94:
  - heater_on sequence 1, 1, 0, 0, 1, each one cycle after the sample.
  - SETPOINT=4095, HYST=10 saturates hi=4095.
  - Clearing enable drops heater_on on the next cycle.
- Assert ARESET while RVALID=1 → RVALID=0 asynchronously and all registers read 0 after release.
